// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator core.
//   - DEF_W / DEF_DIGITS : default operand width and BCD display digits
//   - op_e               : operation select encodings
//   - state_e            : control FSM states
package calc_pkg;

    localparam int DEF_W      = 8;
    localparam int DEF_DIGITS = 4;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,  // A + B
        OP_SUB     = 2'b01,  // A - B
        OP_NEG_ADD = 2'b10,  // (-A) + B
        OP_MUL     = 2'b11   // unsigned A * B
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_CONVERT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/calc_if.sv
// calc_if: user-facing signal bundle of the calculator.
//   sw[W-1:0]                 operand data source
//   btn_a, btn_b, btn_go      raw asynchronous buttons
//   op                        operation select, sampled on go
//   result_bcd[4*DIGITS-1:0]  magnitude of last result, digit 0 in [3:0]
//   sign, ovf, busy, done     status flags
// Modports: master drives the inputs (board / bench), slave is the core.
interface calc_if import calc_pkg::*; #(
    parameter int W      = DEF_W,
    parameter int DIGITS = DEF_DIGITS
);

    logic [W-1:0]          sw;
    logic                  btn_a;
    logic                  btn_b;
    logic                  btn_go;
    op_e                   op;
    logic [4*DIGITS-1:0]   result_bcd;
    logic                  sign;
    logic                  ovf;
    logic                  busy;
    logic                  done;

    modport master (
        output sw, btn_a, btn_b, btn_go, op,
        input  result_bcd, sign, ovf, busy, done
    );

    modport slave (
        input  sw, btn_a, btn_b, btn_go, op,
        output result_bcd, sign, ovf, busy, done
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one input bit per cycle.
//   clk, rst   clock, synchronous active-high reset
//   start      loads bin and begins an N-cycle conversion
//   bin[N-1:0] unsigned binary input, sampled on start
//   busy       conversion in progress (N cycles after start)
//   done       high in the final conversion cycle
//   bcd        BCD value after the current step; final when done=1
//   ovf        value does not fit in DIGITS digits; final when done=1
// bcd/ovf/done are combinational views of the last step so the caller can
// capture the finished value on the same edge that completes it.
module bin2bcd_seq #(
    parameter int N      = 16,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N-1:0]        bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(N + 1);

    logic [N-1:0]     bin_q;
    logic [BW-1:0]    bcd_q;
    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    bcd_shift;
    logic             out_bit;
    logic             ovf_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt;

    // Add-3 correction on every digit that would reach >= 10 after shifting.
    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // A 1 shifted out of the top digit means the value has reached 10^DIGITS;
    // it is remembered sticky for the rest of the conversion.
    assign bcd_shift = {bcd_adj[BW-2:0], bin_q[N-1]};
    assign out_bit   = bcd_adj[BW-1];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: the shift/BCD datapath registers are reset along with control, so
    // after rst every register holds a defined value, not leftovers of an
    // aborted conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            cnt    <= CNT_W'(N);
        end else if (busy_q) begin
            bin_q <= bin_q << 1;
            bcd_q <= bcd_shift;
            ovf_q <= ovf_q | out_bit;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt == CNT_W'(1));
    assign bcd  = bcd_shift;
    assign ovf  = ovf_q | out_bit;

endmodule

// File: rtl/calc_core.sv
// calc_core: button-driven signed add/sub/negate and unsigned multiply with
// BCD magnitude display.
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset
//   bus  calc_if.slave: sw, btn_a, btn_b, btn_go, op in;
//        result_bcd, sign, ovf, busy, done out
// Flow: IDLE --go--> COMPUTE (1 cycle, or W for multiply) --> CONVERT (2W
// cycles, double-dabble) --> DONE (1 cycle, done=1) --> IDLE.
module calc_core import calc_pkg::*; #(
    parameter int W      = DEF_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic  clk,
    input  logic  rst,
    calc_if.slave bus
);

    localparam int                 CW    = $clog2(W);
    localparam logic [CW-1:0]      LAST  = CW'(W - 1);
    localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

    // ---------------- button synchronisers / edge detectors ----------------
    // Bit order: 0 = btn_a, 1 = btn_b, 2 = btn_go.
    logic [2:0] btn_raw, sync1, sync2, prev, pulse;
    logic [1:0] fill;

    assign btn_raw = {bus.btn_go, bus.btn_b, bus.btn_a};

    // prev resets to 1 and is held there until the synchroniser has refilled
    // with real button samples, so a button held through reset cannot look
    // like a fresh 0->1 edge when rst drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '1;
            fill  <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            if (fill[1]) begin
                prev <= sync2;
            end
        end
    end

    assign pulse = sync2 & ~prev;

    logic load_a, load_b, go;
    assign load_a = pulse[0];
    assign load_b = pulse[1];
    assign go     = pulse[2];

    // ---------------- control FSM ----------------
    state_e         state, state_nxt;
    logic           busy_int;
    logic           compute_last;
    logic           conv_start;
    logic           conv_busy, conv_done, conv_ovf;
    logic [4*DIGITS-1:0] conv_bcd;
    op_e            op_q;
    logic [CW-1:0]  cyc;

    assign busy_int     = (state == ST_COMPUTE) || (state == ST_CONVERT);
    assign compute_last = (op_q != OP_MUL) || (cyc == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        conv_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (compute_last) begin
                    state_nxt  = ST_CONVERT;
                    conv_start = 1'b1;
                end
            end
            ST_CONVERT: begin
                // Converter finished: capture. Converter idle without a done
                // means it lost its job; fall back rather than hang.
                if (conv_done)       state_nxt = ST_DONE;
                else if (!conv_busy) state_nxt = ST_IDLE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    logic [W-1:0]   a_q, b_q;       // user-loaded operands
    logic [W-1:0]   a_op, b_op;     // operands frozen at go
    logic [2*W-1:0] mcand, prod, prod_nxt;
    logic [W-1:0]   mplier;
    logic [W:0]     ext_a, ext_b, sum, abs_sum;
    logic [2*W-1:0] mag;
    logic           res_neg, sign_pend;
    logic [4*DIGITS-1:0] result_q;
    logic           sign_q, ovf_q;

    // W+1 bits hold every add/sub/negate result, including -(-2^(W-1)).
    assign ext_a = {a_op[W-1], a_op};
    assign ext_b = {b_op[W-1], b_op};

    always_comb begin
        sum = '0;
        case (op_q)
            OP_ADD:     sum = ext_a + ext_b;
            OP_SUB:     sum = ext_a - ext_b;
            OP_NEG_ADD: sum = ext_b - ext_a;
            default:    sum = '0;
        endcase
    end

    // Unsigned negate of W+1 bits yields 2^W correctly for the -2^W case.
    assign abs_sum  = sum[W] ? ((W+1)'(0) - sum) : sum;
    assign prod_nxt = prod + (mplier[0] ? mcand : '0);
    assign res_neg  = (op_q != OP_MUL) && sum[W];

    // The converter is started in the last COMPUTE cycle, so the multiply
    // feeds it the product including this cycle's partial term.
    assign mag = (op_q == OP_MUL) ? prod_nxt : {{(W-1){1'b0}}, abs_sum};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            a_op      <= '0;
            b_op      <= '0;
            op_q      <= OP_ADD;
            cyc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            sign_pend <= 1'b0;
            result_q  <= '0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (!busy_int) begin
                if (load_a) a_q <= bus.sw;
                if (load_b) b_q <= bus.sw;
            end

            if (state == ST_IDLE && go) begin
                a_op   <= a_q;
                b_op   <= b_q;
                op_q   <= bus.op;
                cyc    <= '0;
                prod   <= '0;
                mcand  <= {{W{1'b0}}, a_q};
                mplier <= b_q;
            end else if (state == ST_COMPUTE) begin
                cyc    <= cyc + CW'(1);
                prod   <= prod_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end

            if (conv_start) begin
                sign_pend <= res_neg;
            end

            if (state == ST_CONVERT && conv_done) begin
                result_q <= conv_ovf ? NINES : conv_bcd;
                ovf_q    <= conv_ovf;
                sign_q   <= sign_pend;
            end
        end
    end

    bin2bcd_seq #(
        .N      (2 * W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (mag),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    assign bus.result_bcd = result_q;
    assign bus.sign       = sign_q;
    assign bus.ovf        = ovf_q;
    assign bus.busy       = busy_int;
    assign bus.done       = (state == ST_DONE);

endmodule

// File: doc/calc_core.md
CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 Parameter W, default 8, operand width in bits (signed two's complement, W >= 4).
REQ-002 Parameter DIGITS, default 4, number of BCD output digits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 sw  in  W  operand data source.
REQ-006 btn_a / btn_b  in  1 each  asynchronous buttons; rising edge loads sw into operand A / B.
REQ-007 btn_go  in  1  asynchronous button; rising edge starts an operation.
REQ-008 op  in  2  operation select: 00 A+B, 01 A-B, 10 (-A)+B, 11 unsigned A*B; sampled on go.
REQ-009 result_bcd  out  4*DIGITS  magnitude of last result, BCD, digit 0 in bits [3:0].
REQ-010 sign / ovf / busy / done  out  1 each  result negative / magnitude exceeds display range / operation in progress / one-cycle completion pulse.

Function
REQ-011 Each button SHALL pass through a 2-flop synchroniser followed by a previous-value flop; a pulse SHALL be one clk wide on 0->1 of the synchronised signal.
REQ-012 A load pulse SHALL write sw to A (or B) the following cycle when busy=0, and SHALL be ignored when busy=1.
REQ-013 Simultaneous A and B pulses SHALL load both registers from the same sw value.
REQ-014 FSM states: IDLE, COMPUTE, CONVERT, DONE; busy=1 in COMPUTE and CONVERT only.
REQ-015 IDLE -> COMPUTE on go pulse, latching op, A and B; go pulses outside IDLE SHALL be ignored.
REQ-016 Add/sub/negate: signed W-bit operands sign-extended to W+1 bits; COMPUTE lasts exactly 1 cycle.
REQ-017 Multiply: operands unsigned, 2W-bit product via shift-add, one bit per cycle; COMPUTE lasts exactly W cycles; sign=0.
REQ-018 Negate of the most negative A (-2^(W-1)) SHALL yield +2^(W-1) without wrap.
REQ-019 Magnitude = absolute value of result; sign = 1 iff result < 0; zero result gives sign=0.
REQ-020 CONVERT: sequential double-dabble on the 2W-bit magnitude, exactly 2W cycles, then DONE.
REQ-021 If magnitude > 10^DIGITS - 1, ovf=1 and result_bcd SHALL saturate to all digits 9; else ovf=0.
REQ-022 result_bcd, sign and ovf SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-023 DONE lasts 1 cycle with done=1, then IDLE.
REQ-024 done SHALL rise exactly 1 + C + 2W cycles after the cycle in which the go pulse is high (C = 1 add/sub/negate, C = W multiply): W=8 -> 18 and 25 cycles.
REQ-025 Operand loads SHALL NOT affect an operation in progress.

Reset
REQ-026 rst SHALL force state IDLE; A, B, result_bcd, sign, ovf, busy, done and datapath registers to 0.
REQ-027 Synchroniser flops SHALL reset to 0 and previous-value flops to 1, so a button held through reset produces no pulse until released and pressed again.
REQ-028 rst asserted mid-COMPUTE or mid-CONVERT SHALL abort the operation with no done pulse.

Structure
REQ-029 Package calc_pkg SHALL hold op encodings, the FSM state type, and default W and DIGITS constants.
REQ-030 Sub-module bin2bcd_seq (start/busy/done, parametrised input width and DIGITS) SHALL implement CONVERT; the synchroniser/edge detector MAY be a generate loop in calc_core.

Verification
REQ-031 W=8: A=25, B=100, op=00, go -> done at cycle 18, result_bcd=0125, sign=0, ovf=0.
REQ-032 A=5, B=20, op=01 -> result_bcd=0015, sign=1; A=20, B=20, op=01 -> 0000, sign=0.
REQ-033 A=0x80, B=0x7F, op=10 -> result_bcd=0255, sign=0 (no wrap).
REQ-034 A=0xFF, B=0xFF, op=11 -> done at cycle 25, ovf=1, result_bcd=9999; A=99, B=99 -> 9801, ovf=0.
REQ-035 go and btn_a pulses while busy -> ignored; A unchanged, single done pulse, result unaffected.
REQ-036 rst during CONVERT -> no done, all outputs 0; btn_go held through reset -> no start until re-pressed.
